module_gate_sequencer: RTL and testbench
========================================

Name: module_gate_sequencer

Overview:
- Per-gate control sequencer directly upstream of module_basis_index.
- Accepts one decoded gate at a time over a valid/ready handshake and latches gate type and qubit positions into holding registers.
- Issues the ld_basis_index2 / ld_basis_index strobes and the alpha / measurement requests in the correct order, then signals gate completion.
- Gate encoding: 0 Hadamard, 1 Phase, 2 CNOT, 3 Measurement.

Parameters:
- num_qubit, 3: number of qubits; a qubit position is legal only when pos < num_qubit.
- CNT_W, 16: width of the retired-gate counter.

Ports:
- clk  input  1  clock.
- rst_new  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous abort; returns the block to IDLE.
- gate_valid  input  1  gate offered.
- gate_ready  output  1  sequencer can accept a gate.
- gate_type  input  2  gate code.
- gate_pos  input  32  target qubit (Hadamard/Phase/Measurement) or control qubit (CNOT).
- gate_pos2  input  32  CNOT target qubit; ignored for other types.
- alpha_start  output  1  one-cycle request to the amplitude unit.
- alpha_done  input  1  amplitude result valid.
- alpha_zero  input  1  first computed alpha is zero; sampled only with alpha_done.
- meas_start  output  1  one-cycle request to the measurement unit.
- meas_done  input  1  basis_index_P valid.
- ld_basis_index  output  1  basis_index load strobe.
- ld_basis_index2  output  1  basis_index2 load strobe.
- initial_alpha_zero  output  1  latched alpha_zero.
- reg_gate_type  output  2  latched gate_type.
- reg_qubit_pos  output  32  latched gate_pos.
- reg2_qubit_pos  output  32  equals reg_qubit_pos (Hadamard bit-flip position).
- reg_qubit_pos2  output  32  latched gate_pos2.
- gate_done  output  1  one-cycle pulse when a gate retires.
- gate_err  output  1  one-cycle pulse when a gate is rejected.
- gate_count  output  CNT_W  number of retired gates.

Behaviour:
- Reset values:
  - All outputs 0, including every strobe and register, and gate_count.
  - Exception: gate_ready = 1. State = IDLE.
- All outputs are registered. gate_ready is high only in IDLE.
- IDLE: on gate_valid && gate_ready, latch type and positions, clear initial_alpha_zero, go to CHECK.
- CHECK (1 cycle), checked in this order:
  - Error conditions: gate_pos >= num_qubit; or CNOT with gate_pos2 >= num_qubit; or CNOT with gate_pos == gate_pos2. On error: pulse gate_err, no strobes issued, go to IDLE.
  - Hadamard: go to LD_B2.
  - Phase: go to ALPHA_REQ.
  - CNOT: go to LD_B.
  - Measurement: go to MEAS_REQ.
- LD_B2: ld_basis_index2 = 1 for one cycle, then go to ALPHA_REQ.
- ALPHA_REQ: alpha_start = 1 for one cycle, then go to ALPHA_WAIT.
- ALPHA_WAIT:
  - Holds until alpha_done, with no timeout.
  - On alpha_done: initial_alpha_zero <= alpha_zero, go to LD_B.
  - initial_alpha_zero is valid in the following cycle, before ld_basis_index rises.
- MEAS_REQ: meas_start = 1 for one cycle, then go to MEAS_WAIT.
- MEAS_WAIT: on meas_done, go to LD_B.
- LD_B: ld_basis_index = 1 for one cycle, then go to DONE.
- DONE: gate_done = 1, gate_count += 1 (wraps modulo 2^CNT_W), go to IDLE.
- Latency from accept to gate_done:
  - CNOT: 3 cycles.
  - Hadamard: 6 + alpha wait.
  - Phase: 5 + alpha wait.
  - Measurement: 5 + meas wait.
  - Back-to-back gates: next accept occurs 1 cycle after gate_done.
- Holding registers (reg_*) stay stable from accept until the next accept. They are not cleared on gate_done.
- alpha_done / meas_done asserted outside their wait states: ignored.
- alpha_done in the same cycle as alpha_start: ignored; the sequencer waits for a later pulse.
- flush:
  - Has priority over every transition.
  - Next state IDLE; all strobes deasserted; no gate_done; gate_count unchanged; holding registers retained.
  - flush in the same cycle as gate_valid: the gate is not accepted.
- rst_new mid-gate: immediate return to the reset values above, with no strobe glitch after release.
- At most one of ld_basis_index, ld_basis_index2, alpha_start, meas_start is high in any cycle.

Decomposition:
- Shared package qcm_pkg:
  - Gate codes GATE_H=2'd0, GATE_P=2'd1, GATE_CNOT=2'd2, GATE_MEAS=2'd3.
  - State enum seq_state_t.
- Single module; no sub-module is warranted.

Test Plan:
- CNOT, num_qubit=3, pos=0, pos2=2 → in this order: accept, gate_err=0, ld_basis_index pulse 2 cycles after accept, gate_done 3 cycles after accept, gate_count=1, reg_qubit_pos=0, reg_qubit_pos2=2.
- Hadamard, pos=1, alpha_done with alpha_zero=1 four cycles after alpha_start → in this order: ld_basis_index2 pulse, then alpha_start, then initial_alpha_zero=1 before the ld_basis_index pulse, then gate_done; reg2_qubit_pos=1.
- Measurement, meas_done 10 cycles after meas_start → ld_basis_index exactly 1 cycle after meas_done; alpha_start never asserted.
- Illegal gates: Hadamard pos=3, then CNOT pos=pos2=1 → gate_err pulse each, no strobes, gate_count unchanged, gate_ready high again 2 cycles after accept.
- flush during ALPHA_WAIT, then stray alpha_done → IDLE, no ld_basis_index, no gate_done; the next Phase gate runs normally.
- rst_new asserted during MEAS_WAIT, then CNT_W=2 with 5 CNOTs back-to-back → after reset all outputs are at reset values and gate_ready=1; gate_count wraps to 1, one accept per 4 cycles.

Source files
------------

// File: rtl/qcm_pkg.sv
// Shared definitions for the quantum control sequencer slice:
// gate codes and the per-gate sequencer state encoding.
package qcm_pkg;

  localparam logic [1:0] GATE_H    = 2'd0;
  localparam logic [1:0] GATE_P    = 2'd1;
  localparam logic [1:0] GATE_CNOT = 2'd2;
  localparam logic [1:0] GATE_MEAS = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_LD_B2,
    S_ALPHA_REQ,
    S_ALPHA_WAIT,
    S_MEAS_REQ,
    S_MEAS_WAIT,
    S_LD_B,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/module_gate_sequencer.sv
// Per-gate control sequencer: accepts one decoded gate, validates it and
// issues basis-index load strobes and alpha/measurement requests in order.
module module_gate_sequencer
  import qcm_pkg::*;
#(
  parameter int unsigned num_qubit = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_new,
  input  logic             flush,
  input  logic             gate_valid,
  output logic             gate_ready,
  input  logic [1:0]       gate_type,
  input  logic [31:0]      gate_pos,
  input  logic [31:0]      gate_pos2,
  output logic             alpha_start,
  input  logic             alpha_done,
  input  logic             alpha_zero,
  output logic             meas_start,
  input  logic             meas_done,
  output logic             ld_basis_index,
  output logic             ld_basis_index2,
  output logic             initial_alpha_zero,
  output logic [1:0]       reg_gate_type,
  output logic [31:0]      reg_qubit_pos,
  output logic [31:0]      reg2_qubit_pos,
  output logic [31:0]      reg_qubit_pos2,
  output logic             gate_done,
  output logic             gate_err,
  output logic [CNT_W-1:0] gate_count
);

  seq_state_t state, state_next;
  logic       accept;
  logic       gate_bad;

  assign reg2_qubit_pos = reg_qubit_pos;

  always_comb begin
    accept   = gate_valid && gate_ready && !flush;
    gate_bad = (reg_qubit_pos >= num_qubit) ||
               ((reg_gate_type == GATE_CNOT) &&
                ((reg_qubit_pos2 >= num_qubit) || (reg_qubit_pos == reg_qubit_pos2)));
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:       if (accept) state_next = S_CHECK;
      S_CHECK: begin
        if (gate_bad) begin
          state_next = S_IDLE;
        end else begin
          unique case (reg_gate_type)
            GATE_H:    state_next = S_LD_B2;
            GATE_P:    state_next = S_ALPHA_REQ;
            GATE_CNOT: state_next = S_LD_B;
            default:   state_next = S_MEAS_REQ;
          endcase
        end
      end
      S_LD_B2:      state_next = S_ALPHA_REQ;
      S_ALPHA_REQ:  state_next = S_ALPHA_WAIT;
      S_ALPHA_WAIT: if (alpha_done) state_next = S_LD_B;
      S_MEAS_REQ:   state_next = S_MEAS_WAIT;
      S_MEAS_WAIT:  if (meas_done) state_next = S_LD_B;
      S_LD_B:       state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Strobes are decoded from the next state so each one is a clean register output.
  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      gate_ready      <= 1'b1;
      ld_basis_index2 <= 1'b0;
      alpha_start     <= 1'b0;
      meas_start      <= 1'b0;
      ld_basis_index  <= 1'b0;
      gate_done       <= 1'b0;
      gate_err        <= 1'b0;
      gate_count      <= '0;
    end else begin
      gate_ready      <= (state_next == S_IDLE);
      ld_basis_index2 <= (state_next == S_LD_B2);
      alpha_start     <= (state_next == S_ALPHA_REQ);
      meas_start      <= (state_next == S_MEAS_REQ);
      ld_basis_index  <= (state_next == S_LD_B);
      gate_done       <= (state_next == S_DONE);
      gate_err        <= (state == S_CHECK) && gate_bad && !flush;
      if (state_next == S_DONE) gate_count <= gate_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      reg_gate_type      <= '0;
      reg_qubit_pos      <= '0;
      reg_qubit_pos2     <= '0;
      initial_alpha_zero <= 1'b0;
    end else if (accept) begin
      reg_gate_type      <= gate_type;
      reg_qubit_pos      <= gate_pos;
      reg_qubit_pos2     <= gate_pos2;
      initial_alpha_zero <= 1'b0;
    end else if ((state == S_ALPHA_WAIT) && alpha_done && !flush) begin
      initial_alpha_zero <= alpha_zero;
    end
  end

endmodule

// File: tb/tb_module_gate_sequencer.sv
// Randomized self-checking bench for module_gate_sequencer: a per-gate event
// schedule derived from the gate rules predicts every output on every cycle.
module tb_module_gate_sequencer;
  import qcm_pkg::*;

  localparam int unsigned NQ = 3;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_new;
  logic          flush;
  logic          gate_valid;
  logic          gate_ready;
  logic [1:0]    gate_type;
  logic [31:0]   gate_pos;
  logic [31:0]   gate_pos2;
  logic          alpha_start;
  logic          alpha_done;
  logic          alpha_zero;
  logic          meas_start;
  logic          meas_done;
  logic          ld_basis_index;
  logic          ld_basis_index2;
  logic          initial_alpha_zero;
  logic [1:0]    reg_gate_type;
  logic [31:0]   reg_qubit_pos;
  logic [31:0]   reg2_qubit_pos;
  logic [31:0]   reg_qubit_pos2;
  logic          gate_done;
  logic          gate_err;
  logic [CW-1:0] gate_count;

  always #5 clk = ~clk;

  module_gate_sequencer #(.num_qubit(NQ), .CNT_W(CW)) dut (
    .clk(clk), .rst_new(rst_new), .flush(flush),
    .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_type(gate_type), .gate_pos(gate_pos), .gate_pos2(gate_pos2),
    .alpha_start(alpha_start), .alpha_done(alpha_done), .alpha_zero(alpha_zero),
    .meas_start(meas_start), .meas_done(meas_done),
    .ld_basis_index(ld_basis_index), .ld_basis_index2(ld_basis_index2),
    .initial_alpha_zero(initial_alpha_zero),
    .reg_gate_type(reg_gate_type), .reg_qubit_pos(reg_qubit_pos),
    .reg2_qubit_pos(reg2_qubit_pos), .reg_qubit_pos2(reg_qubit_pos2),
    .gate_done(gate_done), .gate_err(gate_err), .gate_count(gate_count)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: what the holding registers and counter should hold.
  logic [1:0]    m_type;
  logic [31:0]   m_pos;
  logic [31:0]   m_pos2;
  logic [CW-1:0] m_count;
  logic          m_iaz;

  localparam logic [6:0] IDLE_VEC = 7'b1000000;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] obs();
    return {gate_ready, ld_basis_index2, alpha_start, meas_start,
            ld_basis_index, gate_done, gate_err};
  endfunction

  task automatic check_all(input string tag, input logic [6:0] exp_vec);
    check({tag, ".strobes"}, obs(), exp_vec);
    check({tag, ".count"}, gate_count, m_count);
    check({tag, ".iaz"}, initial_alpha_zero, m_iaz);
    check({tag, ".regs"}, {reg_gate_type, reg_qubit_pos, reg_qubit_pos2},
          {m_type, m_pos, m_pos2});
    check({tag, ".reg2"}, reg2_qubit_pos, m_pos);
  endtask

  task automatic drive_noise();
    gate_valid = 1'b0;
    gate_type  = 2'($urandom);
    gate_pos   = $urandom;
    gate_pos2  = $urandom;
    alpha_done = ($urandom_range(0, 3) == 0);
    alpha_zero = 1'($urandom);
    meas_done  = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all("idle", IDLE_VEC);
      drive_noise();
      flush = ($urandom_range(0, 3) == 0);
    end
  endtask

  // f: cycle (relative to accept) carrying flush, -1 for none.
  // r: cycle at which rst_new is raised, -1 for none.
  // w: cycles from the request strobe to the completion pulse (>=1).
  task automatic run_gate(input logic [1:0] t, input logic [31:0] p, input logic [31:0] p2,
                          input int w, input int f, input int r, input logic az);
    int  ldb2_c = -1, as_c = -1, ms_c = -1, ad_c = -1, md_c = -1;
    int  ldb_c = -1, done_c = -1, err_c = -1, d, last;
    bit  bad, trunc;
    logic [6:0] ev;
    bad = (p >= NQ) || ((t == GATE_CNOT) && ((p2 >= NQ) || (p == p2)));
    if (bad) begin
      err_c = 2;
    end else begin
      case (t)
        GATE_CNOT: begin ldb_c = 2; done_c = 3; end
        GATE_H: begin
          ldb2_c = 2; as_c = 3; ad_c = 3 + w; ldb_c = 4 + w; done_c = 5 + w;
        end
        GATE_P: begin
          as_c = 2; ad_c = 2 + w; ldb_c = 3 + w; done_c = 4 + w;
        end
        default: begin
          ms_c = 2; md_c = 2 + w; ldb_c = 3 + w; done_c = 4 + w;
        end
      endcase
    end
    d = bad ? 2 : done_c;

    @(negedge clk);
    check_all("accept_idle", IDLE_VEC);
    drive_noise();
    gate_valid = 1'b1;
    gate_type  = t;
    gate_pos   = p;
    gate_pos2  = p2;
    flush      = (f == 0);
    if (f == 0) begin
      @(negedge clk);
      check_all("flush_accept", IDLE_VEC);
      drive_noise();
      flush = 1'b0;
      return;
    end
    m_type = t;
    m_pos  = p;
    m_pos2 = p2;
    m_iaz  = 1'b0;
    last   = (f > 0 && f < d) ? f + 1 : d;

    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == r) begin
        rst_new = 1'b1;
        #1;
        m_type = '0; m_pos = '0; m_pos2 = '0; m_count = '0; m_iaz = 1'b0;
        check_all("reset_mid", IDLE_VEC);
        gate_valid = 1'b0; flush = 1'b0; alpha_done = 1'b0; meas_done = 1'b0;
        @(negedge clk);
        rst_new = 1'b0;
        return;
      end
      trunc = (f > 0) && (f < d) && (k == f + 1);
      if (trunc) begin
        ev = IDLE_VEC;
      end else begin
        ev = {(k == err_c), (k == ldb2_c), (k == as_c), (k == ms_c),
              (k == ldb_c), (k == done_c), (k == err_c)};
        if (k == done_c) m_count = m_count + CW'(1);
      end
      if ((ad_c > 0) && (k == ad_c + 1) && !((f > 0) && (f <= ad_c))) m_iaz = az;
      check_all("gate", ev);

      drive_noise();
      flush = (k == f);
      if (k == ad_c) begin
        alpha_done = 1'b1;
        alpha_zero = az;
      end else if ((as_c > 0) && (k > as_c) && (k < ad_c)) begin
        alpha_done = 1'b0;
      end
      if (k == md_c) meas_done = 1'b1;
      else if ((ms_c > 0) && (k > ms_c) && (k < md_c)) meas_done = 1'b0;
    end
  endtask

  initial begin
    rst_new    = 1'b1;
    flush      = 1'b0;
    gate_valid = 1'b0;
    gate_type  = '0;
    gate_pos   = '0;
    gate_pos2  = '0;
    alpha_done = 1'b0;
    alpha_zero = 1'b0;
    meas_done  = 1'b0;
    m_type = '0; m_pos = '0; m_pos2 = '0; m_count = '0; m_iaz = 1'b0;

    @(negedge clk);
    check_all("reset", IDLE_VEC);
    @(negedge clk);
    rst_new = 1'b0;

    // Directed scenarios
    run_gate(GATE_CNOT, 0, 2, 1, -1, -1, 1'b0);
    run_gate(GATE_H,    1, 0, 4, -1, -1, 1'b1);
    run_gate(GATE_MEAS, 0, 0, 10, -1, -1, 1'b0);
    run_gate(GATE_H,    3, 0, 1, -1, -1, 1'b0);
    run_gate(GATE_CNOT, 1, 1, 1, -1, -1, 1'b0);
    run_gate(GATE_P,    2, 0, 5, 4, -1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all("stray_done", IDLE_VEC);
      drive_noise();
      alpha_done = 1'b1;
      meas_done  = 1'b1;
      flush      = 1'b0;
    end
    run_gate(GATE_P,    2, 0, 2, -1, -1, 1'b1);
    run_gate(GATE_CNOT, 0, 1, 1, 0, -1, 1'b0);
    run_gate(GATE_MEAS, 1, 0, 8, -1, 5, 1'b0);
    for (int i = 0; i < 5; i++) run_gate(GATE_CNOT, 2, 0, 1, -1, -1, 1'b0);
    idle(2);

    // Randomized gate stream
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  t;
      logic [31:0] p, p2;
      int          w, f;
      t  = 2'($urandom);
      p  = 32'($urandom_range(0, 3));
      p2 = 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) p = $urandom;
      w  = $urandom_range(1, 6);
      f  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
      run_gate(t, p, p2, w, f, -1, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
